// File: rtl/wisc_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by dmem_responder and dmem_array; DMEM_ERR_EN does not change anything here.
package wisc_pkg;

    localparam int DATA_W = 16;

    typedef enum logic {
        OP_RD,
        OP_WR
    } dmem_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word array for the data-memory responder.
// Writes on the clock edge; the read path is combinational on the same index.
module dmem_array
    import wisc_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents are left unreset on purpose: software owns memory initialisation.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, completes it LATENCY cycles later.
// Optional misaligned-access error output enabled by defining DMEM_ERR_EN.
//
// state  | meaning
// S_IDLE | waiting for a request; stall follows req combinationally
// S_BUSY | access in flight, down-counter running, stall high
// S_DONE | access committed on entry; done pulses, requests ignored
module dmem_responder
    import wisc_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              halt,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done
`ifdef DMEM_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int CNT_W = 4;

    dmem_state_t       state_q, state_d;
    dmem_op_t          op_q, op_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req;
    logic              commit;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_addr;

    assign req = (mem_read | mem_write) & ~halt;
    assign unused_addr = ^{addr[15:ADDR_W+1], addr[0]};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = mem_write ? OP_WR : OP_RD;
                    idx_d   = addr[ADDR_W:1];
                    wdata_d = wdata;
`ifdef DMEM_ERR_EN
                    mis_d   = addr[0];
`else
                    mis_d   = 1'b0;
`endif
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The _d copies hold the access being committed, whether latched this edge or earlier.
    always_comb begin
        arr_we  = commit & (op_d == OP_WR) & ~mis_d;
        rdata_d = rdata_q;
        if (commit && (op_d == OP_RD)) begin
            rdata_d = mis_d ? '0 : arr_rdata;
        end
        done_d = commit;
        err_d  = commit & mis_d;
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (idx_d),
        .wdata (wdata_d),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign stall = ((state_q == S_IDLE) & req) | (state_q == S_BUSY);

`ifdef DMEM_ERR_EN
    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=3 (a_*) and one at LATENCY=1 (b_*).
module tb_dmem_responder;
    import wisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_rd, a_wr, a_halt;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        a_stall, a_done, a_err;

    logic        b_rd, b_wr, b_halt;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic        b_stall, b_done, b_err;

    int          checks = 0;
    int          failures = 0;
    int          b_done_cnt = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (a_rd),
        .mem_write (a_wr),
        .halt      (a_halt),
        .addr      (a_addr),
        .wdata     (a_wdata),
        .rdata     (a_rdata),
        .stall     (a_stall),
        .done      (a_done)
`ifdef DMEM_ERR_EN
        ,
        .err       (a_err)
`endif
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (b_rd),
        .mem_write (b_wr),
        .halt      (b_halt),
        .addr      (b_addr),
        .wdata     (b_wdata),
        .rdata     (b_rdata),
        .stall     (b_stall),
        .done      (b_done)
`ifdef DMEM_ERR_EN
        ,
        .err       (b_err)
`endif
    );

`ifndef DMEM_ERR_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    always @(negedge clk) begin
        if (b_done === 1'b1) b_done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one access and holds it until done, scrambling addr/wdata after the
    // accept edge so that only latched copies can produce the right result.
    task automatic access(input bit use_b, input string tag, input logic rd, input logic wr,
                          input logic [15:0] ad, input logic [15:0] wd, input logic mid_halt,
                          input logic exp_err, input logic [15:0] exp_rdata);
        int   n;
        logic stall_bad;
        logic dn, st;
        @(negedge clk);
        if (use_b) begin b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = wd; b_halt = 1'b0; end
        else       begin a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd; a_halt = 1'b0; end
        #1;
        n = 0;
        stall_bad = 1'b0;
        dn = use_b ? b_done : a_done;
        while (dn !== 1'b1 && n < 20) begin
            st = use_b ? b_stall : a_stall;
            if (st !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
            if (use_b) begin b_addr = ~ad; b_wdata = ~wd; b_halt = mid_halt; end
            else       begin a_addr = ~ad; a_wdata = ~wd; a_halt = mid_halt; end
            #1;
            n++;
            dn = use_b ? b_done : a_done;
        end
        chk({tag, "_latency"}, 32'(n), use_b ? 32'd1 : 32'd3);
        chk({tag, "_stall_before_done"}, {31'd0, stall_bad}, 32'd0);
        chk({tag, "_stall_in_done"}, {31'd0, use_b ? b_stall : a_stall}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, use_b ? b_rdata : a_rdata}, {16'd0, exp_rdata});
        chk({tag, "_err"}, {31'd0, use_b ? b_err : a_err}, {31'd0, exp_err});
        if (use_b) begin b_rd = 1'b0; b_wr = 1'b0; b_halt = 1'b0; end
        else       begin a_rd = 1'b0; a_wr = 1'b0; a_halt = 1'b0; end
    endtask

    initial begin
        logic bad;
        a_rd = 0; a_wr = 0; a_halt = 0; a_addr = 0; a_wdata = 0;
        b_rd = 0; b_wr = 0; b_halt = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_a_rdata", {16'd0, a_rdata}, 32'd0);
        chk("reset_a_done", {31'd0, a_done}, 32'd0);
        chk("reset_a_stall", {31'd0, a_stall}, 32'd0);
        chk("reset_a_err", {31'd0, a_err}, 32'd0);
        chk("reset_b_rdata", {16'd0, b_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load on the LATENCY=3 instance, plus an aliased address above ADDR_W.
        access(0, "t1_store", 0, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000);
        access(0, "t1_load", 1, 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF);
        access(0, "t1_wrap_load", 1, 0, 16'h0810, 16'h0000, 0, 0, 16'hBEEF);

        // Back-to-back on the LATENCY=1 instance.
        access(1, "t2_store", 0, 1, 16'h0002, 16'h1234, 0, 0, 16'h0000);
        access(1, "t2_load", 1, 0, 16'h0002, 16'h0000, 0, 0, 16'h1234);
        repeat (3) @(negedge clk);
        #1;
        chk("t2_done_count", 32'(b_done_cnt), 32'd2);
        chk("t2_done_idle", {31'd0, b_done}, 32'd0);

        // Both request lines high: write priority, rdata untouched.
        access(0, "t3_both", 1, 1, 16'h0004, 16'h5555, 0, 0, 16'hBEEF);
        access(0, "t3_load", 1, 0, 16'h0004, 16'h0000, 0, 0, 16'h5555);

        // halt blocks acceptance; halt arriving during BUSY does not.
        @(negedge clk);
        a_halt = 1; a_rd = 1; a_addr = 16'h0010;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (a_stall !== 1'b0 || a_done !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("t4_halt_blocks", {31'd0, bad}, 32'd0);
        a_halt = 0; a_rd = 0;
        access(0, "t4_halt_in_busy", 1, 0, 16'h0010, 16'h0000, 1, 0, 16'hBEEF);

        // Reset in the middle of a store aborts it.
        access(0, "t5_prior", 0, 1, 16'h0020, 16'h1111, 0, 0, 16'hBEEF);
        @(negedge clk);
        a_wr = 1; a_addr = 16'h0020; a_wdata = 16'hAAAA;
        @(negedge clk);
        #1;
        chk("t5_busy_stall", {31'd0, a_stall}, 32'd1);
        rst_n = 1'b0;
        a_wr = 0;
        #1;
        chk("t5_rst_rdata", {16'd0, a_rdata}, 32'd0);
        chk("t5_rst_done", {31'd0, a_done}, 32'd0);
        chk("t5_rst_stall", {31'd0, a_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, "t5_load", 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h1111);

`ifdef DMEM_ERR_EN
        // Misaligned store is suppressed; misaligned load returns zero.
        access(0, "t6_store_mis", 0, 1, 16'h0011, 16'h7777, 0, 1, 16'h1111);
        access(0, "t6_load_aligned", 1, 0, 16'h0010, 16'h0000, 0, 0, 16'hBEEF);
        access(0, "t6_load_mis", 1, 0, 16'h0011, 16'h0000, 0, 1, 16'h0000);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
